// File: rtl/snek_eat_ctrl.sv
// -----------------------------------------------------------------------------
// snek_eat_ctrl
//
// Consumer side of the food-generator handshake for the snake game. Requests
// new food locations, optionally rejects food that lands on the snake body or
// off-grid (with a bounded number of retries), detects the head reaching the
// food and then issues a one-cycle grow pulse and a saturating score increment.
//
// Optional feature macro: SNEK_FOOD_RECHECK_EN
//   defined   : occupancy / off-grid check, retry counter and place_fail active
//   undefined : CHECK always accepts, place_fail and query_h/query_v tied 0
//
// Parameters
//   GRID_V    : number of valid rows; food_v >= GRID_V is off-grid
//   SCORE_W   : score width, score saturates at all-ones
//   MAX_RETRY : consecutive rejections before a placement is forced
//
// Ports
//   clk           in   pixel clock (only clock)
//   reset         in   synchronous active-high reset
//   frame_tick    in   one-clk pulse per game step
//   head_h/head_v in   registered head position
//   food_h/food_v in   food position from the generator
//   occupied      in   combinational body-occupancy answer for query_h/query_v
//   new_food_flag out  request to the generator (registered)
//   query_h/v     out  occupancy query, food position during CHECK, else 0
//   food_valid    out  food placed and edible (registered)
//   grow          out  one-clk pulse to add a body segment (registered)
//   score         out  foods eaten, saturating (registered)
//   place_fail    out  sticky: a placement was forced (registered)
// -----------------------------------------------------------------------------
module snek_eat_ctrl #(
  parameter int GRID_V    = 25,
  parameter int SCORE_W   = 10,
  parameter int MAX_RETRY = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [4:0]         head_h,
  input  logic [4:0]         head_v,
  input  logic [4:0]         food_h,
  input  logic [4:0]         food_v,
  input  logic               occupied,
  output logic               new_food_flag,
  output logic [4:0]         query_h,
  output logic [4:0]         query_v,
  output logic               food_valid,
  output logic               grow,
  output logic [SCORE_W-1:0] score,
  output logic               place_fail
);

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    WAIT_FOOD = 2'd1,
    CHECK     = 2'd2,
    ARMED     = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  logic hit_s;         // head on food at a frame_tick while armed
  logic retry_wait_s;  // CHECK rejected the food and will ask again

  // Saturating +1 used for the score counter.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    if (&v) begin
      r = v;
    end else begin
      r = v + SCORE_W'(1);
    end
    return r;
  endfunction

  // Eat detection: compare is only made on frame_tick cycles while armed,
  // using the head/food values present before the edge.
  always_comb begin
    hit_s = 1'b0;
    if ((state_r == ARMED) && frame_tick &&
        (head_h == food_h) && (head_v == food_v)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

`ifdef SNEK_FOOD_RECHECK_EN
  localparam int RW = (MAX_RETRY < 16) ? 4 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [31:0]   GRID_V_U  = 32'(GRID_V);

  logic [RW-1:0] retry_r;
  logic          reject_s;
  logic          force_s;   // rejection budget exhausted, accept anyway
  logic [31:0]   food_v_ext;

  assign food_v_ext = {27'd0, food_v};

  // Query the body module with the candidate location only while checking.
  assign query_h = (state_r == CHECK) ? food_h : 5'd0;
  assign query_v = (state_r == CHECK) ? food_v : 5'd0;

  // Placement decision for the CHECK cycle.
  always_comb begin
    reject_s     = occupied || (food_v_ext >= GRID_V_U);
    retry_wait_s = 1'b0;
    force_s      = 1'b0;
    if ((state_r == CHECK) && reject_s) begin
      if (retry_r < RETRY_MAX) begin
        retry_wait_s = 1'b1;
      end else begin
        force_s = 1'b1;
      end
    end else begin
      retry_wait_s = 1'b0;
      force_s      = 1'b0;
    end
  end

  // Consecutive-rejection counter; any exit from CHECK to ARMED clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_r <= '0;
    end else if (state_r == CHECK) begin
      if (retry_wait_s) begin
        retry_r <= retry_r + RW'(1);
      end else begin
        retry_r <= '0;
      end
    end else begin
      retry_r <= retry_r;
    end
  end

  // Sticky forced-placement flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      place_fail <= 1'b0;
    end else if (force_s) begin
      place_fail <= 1'b1;
    end else begin
      place_fail <= place_fail;
    end
  end
`else
  logic unused_s;

  // Without the recheck every placement is accepted on its CHECK cycle.
  assign retry_wait_s = 1'b0;
  assign query_h      = 5'd0;
  assign query_v      = 5'd0;
  assign place_fail   = 1'b0;
  assign unused_s     = ^{occupied, 32'(GRID_V), 32'(MAX_RETRY)};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= INIT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a tick during CHECK is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      INIT: begin
        state_s = WAIT_FOOD;
      end
      WAIT_FOOD: begin
        if (frame_tick) begin
          state_s = CHECK;
        end else begin
          state_s = WAIT_FOOD;
        end
      end
      CHECK: begin
        if (retry_wait_s) begin
          state_s = WAIT_FOOD;
        end else begin
          state_s = ARMED;
        end
      end
      ARMED: begin
        if (hit_s) begin
          state_s = WAIT_FOOD;
        end else begin
          state_s = ARMED;
        end
      end
      default: begin
        state_s = INIT;
      end
    endcase
  end

  // Registered outputs decoded from the next state, so the request rises
  // together with grow and food_valid drops on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_food_flag <= 1'b0;
      food_valid    <= 1'b0;
      grow          <= 1'b0;
      score         <= '0;
    end else begin
      new_food_flag <= (state_s == WAIT_FOOD);
      food_valid    <= (state_s == ARMED);
      grow          <= hit_s;
      if (hit_s) begin
        score <= sat_inc(score);
      end else begin
        score <= score;
      end
    end
  end

endmodule

// File: tb/tb_snek_eat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snek_eat_ctrl
//
// Directed self-checking bench for snek_eat_ctrl. Inputs are driven 1 time
// unit after the rising edge and outputs are sampled at the same point.
// Recheck-specific scenarios follow SNEK_FOOD_RECHECK_EN.
// -----------------------------------------------------------------------------
module tb_snek_eat_ctrl;

  localparam int SCORE_W = 10;

  logic               clk;
  logic               reset;
  logic               frame_tick;
  logic [4:0]         head_h;
  logic [4:0]         head_v;
  logic [4:0]         food_h;
  logic [4:0]         food_v;
  logic               occupied;
  logic               new_food_flag;
  logic [4:0]         query_h;
  logic [4:0]         query_v;
  logic               food_valid;
  logic               grow;
  logic [SCORE_W-1:0] score;
  logic               place_fail;

  int n_cmp;
  int n_err;
  int exp_score;

  snek_eat_ctrl #(
    .GRID_V   (25),
    .SCORE_W  (SCORE_W),
    .MAX_RETRY(15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .head_h       (head_h),
    .head_v       (head_v),
    .food_h       (food_h),
    .food_v       (food_v),
    .occupied     (occupied),
    .new_food_flag(new_food_flag),
    .query_h      (query_h),
    .query_v      (query_v),
    .food_valid   (food_valid),
    .grow         (grow),
    .score        (score),
    .place_fail   (place_fail)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Tick in WAIT_FOOD; the generator presents the new location after the edge.
  task automatic place(input logic [4:0] h, input logic [4:0] v);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    food_h = h;
    food_v = v;
  endtask

  // Tick in ARMED with the head at (h, v).
  task automatic tick_head(input logic [4:0] h, input logic [4:0] v);
    head_h = h;
    head_v = v;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_nff"}, 32'(new_food_flag), 32'd0);
    chk({tag, "_qh"},  32'(query_h),       32'd0);
    chk({tag, "_qv"},  32'(query_v),       32'd0);
    chk({tag, "_fv"},  32'(food_valid),    32'd0);
    chk({tag, "_grow"},32'(grow),          32'd0);
    chk({tag, "_scr"}, 32'(score),         32'd0);
    chk({tag, "_pf"},  32'(place_fail),    32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    frame_tick = 1'b0;
    head_h = 5'd0;
    head_v = 5'd0;
    food_h = 5'd0;
    food_v = 5'd0;
    occupied = 1'b0;
    step();
    step();
    step();
    chk_reset_vals("rst");

    // Release: INIT cycle, then WAIT_FOOD with the request high.
    reset = 1'b0;
    chk("init_nff", 32'(new_food_flag), 32'd0);
    step();
    chk("req_rise", 32'(new_food_flag), 32'd1);
    step();
    step();
    chk("req_hold", 32'(new_food_flag), 32'd1);

    // First placement at (5,7).
    place(5'd5, 5'd7);
    chk("chk_nff", 32'(new_food_flag), 32'd0);
    chk("chk_fv",  32'(food_valid),    32'd0);
`ifdef SNEK_FOOD_RECHECK_EN
    chk("chk_qh", 32'(query_h), 32'd5);
    chk("chk_qv", 32'(query_v), 32'd7);
`else
    chk("chk_qh", 32'(query_h), 32'd0);
    chk("chk_qv", 32'(query_v), 32'd0);
`endif
    step();
    chk("armed_fv",  32'(food_valid), 32'd1);
    chk("armed_scr", 32'(score),      32'd0);
    chk("armed_qh",  32'(query_h),    32'd0);

    // Head on food but no tick: nothing happens.
    head_h = 5'd5;
    head_v = 5'd7;
    step();
    chk("notick_grow", 32'(grow), 32'd0);

    // Eat at (5,7).
    tick_head(5'd5, 5'd7);
    chk("eat_grow", 32'(grow),          32'd1);
    chk("eat_scr",  32'(score),         32'd1);
    chk("eat_nff",  32'(new_food_flag), 32'd1);
    chk("eat_fv",   32'(food_valid),    32'd0);
    step();
    chk("eat_pulse", 32'(grow), 32'd0);

    // Miss: head differs in column only.
    place(5'd3, 5'd4);
    step();
    tick_head(5'd2, 5'd4);
    chk("miss_grow", 32'(grow),       32'd0);
    chk("miss_fv",   32'(food_valid), 32'd1);
    tick_head(5'd3, 5'd4);
    chk("hit2_grow", 32'(grow),  32'd1);
    chk("hit2_scr",  32'(score), 32'd2);
    step();

`ifdef SNEK_FOOD_RECHECK_EN
    // Two occupied placements, then a free one.
    occupied = 1'b1;
    for (int i = 0; i < 2; i++) begin
      place(5'd9, 5'd9);
      step();
      chk("occ_rereq", 32'(new_food_flag), 32'd1);
      chk("occ_fv",    32'(food_valid),    32'd0);
    end
    occupied = 1'b0;
    place(5'd9, 5'd9);
    step();
    chk("occ_acc_fv", 32'(food_valid), 32'd1);
    chk("occ_acc_pf", 32'(place_fail), 32'd0);
    tick_head(5'd9, 5'd9);
    chk("occ_eat_scr", 32'(score), 32'd3);
    step();

    // Off-grid row 28 is rejected, row 24 accepted.
    place(5'd1, 5'd28);
    step();
    chk("offgrid_rereq", 32'(new_food_flag), 32'd1);
    chk("offgrid_fv",    32'(food_valid),    32'd0);
    place(5'd1, 5'd24);
    step();
    chk("edge_row_fv", 32'(food_valid), 32'd1);
    tick_head(5'd1, 5'd24);
    step();

    // 16 rejections: the 16th is forced.
    occupied = 1'b1;
    for (int i = 0; i < 15; i++) begin
      place(5'd2, 5'd2);
      step();
    end
    chk("rej15_fv", 32'(food_valid), 32'd0);
    chk("rej15_pf", 32'(place_fail), 32'd0);
    place(5'd2, 5'd2);
    step();
    chk("forced_fv", 32'(food_valid), 32'd1);
    chk("forced_pf", 32'(place_fail), 32'd1);
    occupied = 1'b0;
    tick_head(5'd2, 5'd2);
    chk("forced_eat", 32'(grow), 32'd1);
    step();
    exp_score = 5;
`else
    // Occupancy is ignored without the recheck.
    occupied = 1'b1;
    place(5'd9, 5'd9);
    step();
    chk("noreck_fv", 32'(food_valid), 32'd1);
    chk("noreck_pf", 32'(place_fail), 32'd0);
    occupied = 1'b0;
    tick_head(5'd9, 5'd9);
    step();
    exp_score = 3;
`endif

    // Fill the score to all-ones, then eat once more.
    while (exp_score < 1023) begin
      place(5'd1, 5'd1);
      step();
      tick_head(5'd1, 5'd1);
      exp_score = exp_score + 1;
    end
    step();
    chk("sat_pre", 32'(score), 32'd1023);
    place(5'd4, 5'd4);
    step();
    tick_head(5'd4, 5'd4);
    chk("sat_grow", 32'(grow),  32'd1);
    chk("sat_scr",  32'(score), 32'd1023);
    step();

    // Reset during CHECK.
    place(5'd6, 5'd6);
    reset = 1'b1;
    step();
    chk_reset_vals("rst_chk");
    reset = 1'b0;
    chk("rst_chk_init", 32'(new_food_flag), 32'd0);
    step();
    chk("rst_chk_req", 32'(new_food_flag), 32'd1);

    // Reset in the cycle of a pending grow.
    place(5'd7, 5'd8);
    step();
    chk("pend_fv", 32'(food_valid), 32'd1);
    head_h = 5'd7;
    head_v = 5'd8;
    frame_tick = 1'b1;
    reset = 1'b1;
    step();
    frame_tick = 1'b0;
    chk_reset_vals("rst_grow");
    reset = 1'b0;
    step();
    chk("rst_grow_req", 32'(new_food_flag), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
